// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int PR_W       = DIVISOR_W + 1;
    localparam int CNT_W      = 3;

    localparam logic [DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = 8'hFF;
    localparam logic [CNT_W-1:0]      ITER_LOAD         = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_sub5.sv
// 5-bit ripple subtractor (a + ~b + 1) built from full-adder cells;
// no_borrow is the final carry and means a >= b.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module sub5
    import seq_divider_pkg::*;
(
    input  logic [PR_W-1:0] a,
    input  logic [PR_W-1:0] b,
    output logic [PR_W-1:0] diff,
    output logic            no_borrow
);

    logic [PR_W-1:0] b_inv_s;
    logic [PR_W:0]   carry_s;

    assign b_inv_s    = ~b;
    assign carry_s[0] = 1'b1;
    assign no_borrow  = carry_s[PR_W];

    for (genvar i = 0; i < PR_W; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b_inv_s[i]),
            .cin  (carry_s[i]),
            .sum  (diff[i]),
            .cout (carry_s[i+1])
        );
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per cycle MSB first, with a direct divide-by-zero completion path.
module seq_divider
    import seq_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    state_e                state_r;
    state_e                state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [PR_W-1:0]       pr_r;
    logic [PR_W-1:0]       pr_shift_s;
    logic [PR_W-1:0]       pr_diff_s;
    logic [PR_W-1:0]       pr_next_s;
    logic [DIVIDEND_W-1:0] q_r;
    logic [DIVIDEND_W-1:0] q_next_s;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic                  no_borrow_s;
    logic                  accept_s;
    logic                  accept_zero_s;
    logic                  last_iter_s;
    logic                  pr_msb_unused_s;

    logic                  busy_r;
    logic                  done_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;
    logic                  div_zero_r;

    // Restored remainder never exceeds divisor-1, so the stored MSB is always 0.
    assign pr_msb_unused_s = pr_r[PR_W-1];

    assign pr_shift_s    = {pr_r[PR_W-2:0], q_r[DIVIDEND_W-1]};
    assign accept_s      = (state_r == IDLE) && start && (divisor != 4'd0);
    assign accept_zero_s = (state_r == IDLE) && start && (divisor == 4'd0);
    assign last_iter_s   = (state_r == RUN) && (cnt_r == 3'd0);

    sub5 u_sub5 (
        .a         (pr_shift_s),
        .b         ({1'b0, dvs_r}),
        .diff      (pr_diff_s),
        .no_borrow (no_borrow_s)
    );

    // One restoring step: keep the difference and set the quotient bit when no borrow.
    always_comb begin
        pr_next_s = pr_shift_s;
        q_next_s  = {q_r[DIVIDEND_W-2:0], 1'b0};
        if (no_borrow_s) begin
            pr_next_s = pr_diff_s;
            q_next_s  = {q_r[DIVIDEND_W-2:0], 1'b1};
        end else begin
            pr_next_s = pr_shift_s;
            q_next_s  = {q_r[DIVIDEND_W-2:0], 1'b0};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == 4'd0) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 3'd0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Working registers: operand latch, partial remainder, shifting quotient, counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= 8'd0;
            pr_r  <= 5'd0;
            dvs_r <= 4'd0;
            cnt_r <= 3'd0;
        end else if (accept_s) begin
            q_r   <= dividend;
            pr_r  <= 5'd0;
            dvs_r <= divisor;
            cnt_r <= ITER_LOAD;
        end else if (state_r == RUN) begin
            q_r   <= q_next_s;
            pr_r  <= pr_next_s;
            cnt_r <= cnt_r - 3'd1;
        end
    end

    // Registered status and result outputs; results change only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 8'd0;
            remainder_r <= 4'd0;
            div_zero_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
            if (accept_zero_s) begin
                quotient_r  <= DIV_ZERO_QUOTIENT;
                remainder_r <= dividend[DIVISOR_W-1:0];
                div_zero_r  <= 1'b1;
            end else if (last_iter_s) begin
                quotient_r  <= q_next_s;
                remainder_r <= pr_next_s[DIVISOR_W-1:0];
                div_zero_r  <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, randomized operands and
// an exhaustive back-to-back sweep against an arithmetic reference.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_cmp;
    int n_err;
    int cur_dvd;
    int cur_dvs;

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s (%0d/%0d): observed %0d expected %0d", tag, cur_dvd, cur_dvs, obs, expv);
        end
    endtask

    // One operation; inj>0 pulses a competing start (100/3) at that edge after acceptance.
    task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs, input int inj);
        int exp_q, exp_r, exp_dz, exp_lat, exp_busy;
        int lat, busy_cnt;
        cur_dvd = int'(dvd);
        cur_dvs = int'(dvs);
        if (dvs == 4'd0) begin
            exp_q = 255; exp_r = int'(dvd) % 16; exp_dz = 1; exp_lat = 0; exp_busy = 0;
        end else begin
            exp_q = int'(dvd) / int'(dvs); exp_r = int'(dvd) % int'(dvs);
            exp_dz = 0; exp_lat = 8; exp_busy = 8;
        end
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat      = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 20) begin
            if (inj != 0 && lat + 1 == inj) begin
                start    = 1'b1;
                dividend = 8'd100;
                divisor  = 4'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (busy === 1'b1) busy_cnt++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_zero", 32'(div_zero), 32'(exp_dz));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        if (exp_dz == 0) begin
            check("invariant", 32'(int'(quotient) * int'(dvs) + int'(remainder)), 32'(dvd));
        end
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_div_zero"}, 32'(div_zero), 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        cur_dvd  = 0;
        cur_dvs  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'd200, 4'd7, 0);
        do_op(8'd255, 4'd15, 0);
        do_op(8'd5, 4'd9, 0);
        do_op(8'd255, 4'd1, 0);
        do_op(8'hA3, 4'd0, 0);
        do_op(8'd200, 4'd7, 4);
        do_op(8'd100, 4'd3, 0);

        // Reset in the middle of a run, after a divide-by-zero left div_zero set.
        do_op(8'hA3, 4'd0, 0);
        cur_dvd  = 200;
        cur_dvs  = 7;
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrun_rst");

        // Start coinciding with reset is dropped.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_done", 32'(done), 32'd0);
        do_op(8'd200, 4'd7, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 0);
        end

        for (int d = 0; d < 256; d++) begin
            for (int s = 0; s < 16; s++) begin
                do_op(d[7:0], s[3:0], 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameters: none; widths fixed at 8-bit dividend and 4-bit divisor, matching the 4-bit x 4-bit -> 8-bit product of the multiplier.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned numerator; sampled with start.
REQ-006 divisor  input  4  unsigned denominator; sampled with start.
REQ-007 busy  output  1  high while iterating.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quotient  output  8  unsigned quotient, registered.
REQ-010 remainder  output  4  unsigned remainder, registered.
REQ-011 div_zero  output  1  divisor was 0 for the last completed operation.

Function
REQ-012 Inverse of the multiplier: restoring shift-subtract division, one quotient bit per cycle, MSB first.
REQ-013 States: IDLE, RUN, DONE; encoding is free, but exactly these three states are used.
REQ-014 IDLE and start=1 at edge k with divisor!=0 -> latch operands, clear the 5-bit partial remainder, load the 3-bit iteration counter with 7, go to RUN.
REQ-015 IDLE and start=1 with divisor==0 -> go directly to DONE; quotient=8'hFF, remainder=dividend[3:0], div_zero=1.
REQ-016 RUN iteration: pr = {pr[3:0], q[7]}; q <<= 1; if pr >= {1'b0,divisor} then pr -= divisor and q[0]=1.
REQ-017 Compare and subtract use one 5-bit ripple subtractor: a + ~b + 1, where carry-out=1 means no borrow and therefore pr >= divisor.
REQ-018 The partial remainder is 5 bits wide, because 2*15-1=29 fits; no overflow is possible.
REQ-019 RUN lasts exactly 8 cycles (edges k+1..k+8); the counter decrements each cycle; at counter==0 go to DONE.
REQ-020 busy=1 exactly in RUN; done=1 exactly in DONE; DONE lasts one cycle, then IDLE.
REQ-021 Latency: start at edge k -> done high during cycle k+9 (normal) or k+1 (divide-by-zero).
REQ-022 Entering DONE updates quotient, remainder and div_zero; they hold until the next entry to DONE.
REQ-023 During RUN the quotient/remainder outputs keep their previous values; the working registers are internal.
REQ-024 start in RUN or DONE is ignored, not queued; dividend/divisor changes after acceptance have no effect.
REQ-025 Invariant on normal completion: quotient*divisor + remainder == dividend and remainder < divisor.

Reset
REQ-026 rst=1 at any edge, including mid-RUN or in DONE: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; counter and working registers cleared.
REQ-027 rst has priority over start on the same edge; a start present while rst=1 is dropped.

Structure
REQ-028 A shared package holds the state typedef (IDLE/RUN/DONE), DIVIDEND_W=8, DIVISOR_W=4 and the 8'hFF divide-by-zero quotient constant.
REQ-029 One sub-module, sub5: a 5-bit ripple subtractor built from the existing fulladder cell, with carry-in tied to 1, outputs diff[4:0] and no_borrow.
REQ-030 No other hierarchy; the FSM, counter and shift registers live in seq_divider.

Verification
REQ-031 dividend=200, divisor=7, start pulse -> done at k+9, quotient=28, remainder=4, div_zero=0; busy high for exactly 8 cycles.
REQ-032 255/15 -> quotient=17, remainder=0; 5/9 -> quotient=0, remainder=5; 255/1 -> quotient=255, remainder=0.
REQ-033 dividend=0xA3, divisor=0 -> done at k+1, quotient=0xFF, remainder=3, div_zero=1, busy never high.
REQ-034 200/7 started, then start with 100/3 at k+4 -> ignored; results 28/4; a subsequent IDLE start with 100/3 -> 33/1.
REQ-035 rst at k+5 during RUN -> next cycle all outputs 0, state IDLE; a new start then completes normally.
REQ-036 Exhaustive sweep of all 256x16 operand pairs with back-to-back starts -> REQ-025 holds, div_zero matches divisor==0, and done pulses exactly once per accepted start.
